// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the Wishbone round-robin arbiter.
//   arb_state_e     : arbiter FSM states (idle, bus owned, watchdog abort)
//   *_DEF           : default parameter values
//   wdt_cnt_width() : width of a counter that must hold 0..limit
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam int unsigned NM_DEF = 4;
  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned TO_DEF = 255;

  function automatic int unsigned wdt_cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational NM-way round-robin priority picker.
//   req_i   : request vector
//   last_i  : index of the previous winner (lowest priority this round)
//   valid_o : at least one request present
//   gnt_o   : one-hot winner
//   idx_o   : binary index of the winner
module rr_pick #(
  parameter int unsigned NM = 4,
  parameter int unsigned IW = $clog2(NM)
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [NM-1:0] gnt_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin : pick
    int unsigned pos;
    pos     = 0;
    valid_o = 1'b0;
    gnt_o   = '0;
    idx_o   = '0;
    // Walk last+1 .. last+NM (mod NM); the first hit wins.
    for (int unsigned i = 1; i <= NM; i++) begin
      pos = (32'(last_i) + i) % NM;
      if (!valid_o && req_i[pos[IW-1:0]]) begin
        valid_o                = 1'b1;
        gnt_o[pos[IW-1:0]]     = 1'b1;
        idx_o                  = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port among NM masters,
// with a watchdog that aborts a stalled cycle by returning an error.
//   clk_i, rstn_i        : clock, async active-low reset
//   m_*_i / m_*_o        : packed per-master request fields and responses
//   s_*_o / s_*_i        : single slave-side port
//   gnt_o                : one-hot current owner (0 when idle)
//   to_evt_o             : one-cycle pulse on watchdog expiry
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NM        = NM_DEF,
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned TO_CYCLES = TO_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NM-1:0]     m_cyc_i,
  input  logic [NM-1:0]     m_stb_i,
  input  logic [NM-1:0]     m_we_i,
  input  logic [NM*AW-1:0]  m_adr_i,
  input  logic [NM*DW-1:0]  m_dat_i,
  input  logic [NM*DW/8-1:0] m_sel_i,
  output logic [DW-1:0]     m_dat_o,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [NM-1:0]     gnt_o,
  output logic              to_evt_o
);

  localparam int unsigned IW = $clog2(NM);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = wdt_cnt_width(TO_CYCLES);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [NM-1:0] gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pick_valid;
  logic [NM-1:0] pick_gnt;
  logic [IW-1:0] pick_idx;

  logic          own;
  logic          own_cyc;
  logic          stall;
  logic          expire;
  int unsigned   own_idx;

  rr_pick #(
    .NM (NM),
    .IW (IW)
  ) u_pick (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  assign own     = (state_q == ST_OWN);
  assign own_idx = 32'(owner_q);
  assign own_cyc = m_cyc_i[owner_q];

  // Slave-side mux: only the owner is visible, and only while in OWN.
  assign s_cyc_o = own & own_cyc;
  assign s_stb_o = own & m_stb_i[owner_q];
  assign s_we_o  = own & m_we_i[owner_q];
  assign s_adr_o = own ? m_adr_i[own_idx*AW +: AW] : '0;
  assign s_dat_o = own ? m_dat_i[own_idx*DW +: DW] : '0;
  assign s_sel_o = own ? m_sel_i[own_idx*SW +: SW] : '0;

  // A slave response in the expiry cycle cancels the stall, so it wins.
  assign stall  = own & s_stb_o & ~s_ack_i & ~s_err_i;
  assign expire = stall & (cnt_q == CW'(TO_CYCLES - 1));

  assign m_dat_o  = s_dat_i;
  assign m_ack_o  = gnt_q & {NM{own & s_ack_i}};
  assign m_err_o  = gnt_q & {NM{own & (s_err_i | expire)}};
  assign to_evt_o = expire;
  assign gnt_o    = gnt_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWN;
          owner_d = pick_idx;
          last_d  = pick_idx;
          gnt_d   = pick_gnt;
        end
      end
      ST_OWN: begin
        if (expire) begin
          state_d = ST_ABORT;
        end else if (!own_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (stall) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NM - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              rstn_i;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*SW-1:0]  m_sel_i;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i;
  logic [NM-1:0]     gnt_o;
  logic              to_evt_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [3:0]  ack;
    logic [3:0]  err;
    logic        evt;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        we;
    logic [3:0]  sel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  wb_rr_arbiter #(
    .NM        (NM),
    .AW        (AW),
    .DW        (DW),
    .TO_CYCLES (TO)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn_i),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_sel_i  (m_sel_i),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .gnt_o    (gnt_o),
    .to_evt_o (to_evt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input int unsigned m, input logic cyc, input logic stb, input logic we,
                     input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc_i[m]           = cyc;
    m_stb_i[m]           = stb;
    m_we_i[m]            = we;
    m_adr_i[m*AW +: AW]  = adr;
    m_dat_i[m*DW +: DW]  = dat;
    m_sel_i[m*SW +: SW]  = sel;
  endtask

  task automatic idle_m(input int unsigned m);
    drv(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic push(input logic [3:0] ack, input logic [3:0] err, input logic evt,
                      input logic [31:0] adr, input logic [31:0] wdat, input logic [31:0] rdat,
                      input logic we, input logic [3:0] sel);
    exp_t e;
    e.ack = ack; e.err = err; e.evt = evt; e.adr = adr;
    e.wdat = wdat; e.rdat = rdat; e.we = we; e.sel = sel;
    sb.push_back(e);
  endtask

  // Response monitor: every ack/err/timeout cycle must match a queued expectation.
  always @(negedge clk) begin
    if (rstn_i === 1'b1 && ((m_ack_o != '0) || (m_err_o != '0) || to_evt_o)) begin
      check("sb_expected", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("mon_ack", 32'(m_ack_o), 32'(mon_e.ack));
        check("mon_err", 32'(m_err_o), 32'(mon_e.err));
        check("mon_evt", 32'(to_evt_o), 32'(mon_e.evt));
        check("mon_adr", s_adr_o, mon_e.adr);
        check("mon_we", 32'(s_we_o), 32'(mon_e.we));
        if (mon_e.we) begin
          check("mon_wdat", s_dat_o, mon_e.wdat);
          check("mon_sel", 32'(s_sel_o), 32'(mon_e.sel));
        end else begin
          check("mon_rdat", m_dat_o, mon_e.rdat);
        end
      end
    end
  end

  initial begin
    rstn_i  = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;

    // Reset state
    smp();
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_scyc", 32'(s_cyc_o), 32'd0);
    check("rst_ack", 32'(m_ack_o), 32'd0);
    check("rst_err", 32'(m_err_o), 32'd0);
    check("rst_evt", 32'(to_evt_o), 32'd0);
    check("rst_sadr", s_adr_o, 32'd0);
    tick(); tick();
    rstn_i = 1'b1;

    // Single write from master 0, slave acks two cycles after strobe
    tick();
    drv(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    smp();
    check("t1_idle_gnt", 32'(gnt_o), 32'd0);
    check("t1_idle_scyc", 32'(s_cyc_o), 32'd0);
    tick(); smp();
    check("t1_gnt", 32'(gnt_o), 32'h1);
    check("t1_scyc", 32'(s_cyc_o), 32'd1);
    check("t1_adr", s_adr_o, 32'h0000_0010);
    check("t1_dat", s_dat_o, 32'hDEAD_BEEF);
    check("t1_noack0", 32'(m_ack_o), 32'd0);
    tick(); smp();
    check("t1_noack1", 32'(m_ack_o), 32'd0);
    tick();
    s_ack_i = 1'b1;
    push(4'b0001, 4'b0000, 1'b0, 32'h10, 32'hDEAD_BEEF, '0, 1'b1, 4'hF);
    smp();
    check("t1_ack", 32'(m_ack_o), 32'h1);
    tick();
    s_ack_i = 1'b0;
    idle_m(0);
    smp();
    check("t1_ack_once", 32'(m_ack_o), 32'd0);
    check("t1_drop_scyc", 32'(s_cyc_o), 32'd0);
    tick(); smp();
    check("t1_rel_gnt", 32'(gnt_o), 32'd0);

    // Reset restores master 0 priority; four simultaneous single accesses
    tick(); rstn_i = 1'b0;
    tick(); rstn_i = 1'b1;
    tick();
    for (int unsigned m = 0; m < 4; m++)
      drv(m, 1'b1, 1'b1, (m % 2 == 0), 32'h100 + 4*m, 32'hA0 + m, 4'hF);
    smp();
    check("t2_idle", 32'(gnt_o), 32'd0);
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      s_ack_i = 1'b1;
      s_dat_i = 32'h5500_0000 + k;
      push(4'(32'd1 << k), 4'b0000, 1'b0, 32'h100 + 4*k, 32'hA0 + k, s_dat_i, (k % 2 == 0), 4'hF);
      smp();
      check($sformatf("t2_gnt%0d", k), 32'(gnt_o), 32'd1 << k);
      check($sformatf("t2_scyc%0d", k), 32'(s_cyc_o), 32'd1);
      tick();
      s_ack_i = 1'b0;
      idle_m(k);
      smp();
      check($sformatf("t2_hold%0d", k), 32'(gnt_o), 32'd1 << k);
      tick(); smp();
      check($sformatf("t2_gap%0d", k), 32'(gnt_o), 32'd0);
    end

    // Master 2 four-beat burst while master 1 waits
    tick();
    drv(2, 1'b1, 1'b1, 1'b1, 32'h200, 32'hB000_0000, 4'hF);
    smp();
    check("t3_idle", 32'(gnt_o), 32'd0);
    tick();
    drv(1, 1'b1, 1'b1, 1'b0, 32'h140, '0, 4'hF);
    for (int unsigned b = 0; b < 4; b++) begin
      if (b > 0) tick();
      drv(2, 1'b1, 1'b1, 1'b1, 32'h200 + 4*b, 32'hB000_0000 + b, 4'hF);
      s_ack_i = 1'b1;
      push(4'b0100, 4'b0000, 1'b0, 32'h200 + 4*b, 32'hB000_0000 + b, '0, 1'b1, 4'hF);
      smp();
      check($sformatf("t3_burst_gnt%0d", b), 32'(gnt_o), 32'h4);
    end
    tick();
    s_ack_i = 1'b0;
    idle_m(2);
    smp();
    check("t3_drop_gnt", 32'(gnt_o), 32'h4);
    tick(); smp();
    check("t3_gap", 32'(gnt_o), 32'd0);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h1234_5678;
    push(4'b0010, 4'b0000, 1'b0, 32'h140, '0, 32'h1234_5678, 1'b0, 4'hF);
    smp();
    check("t3_m1_gnt", 32'(gnt_o), 32'h2);
    tick();
    s_ack_i = 1'b0;
    idle_m(1);
    smp();
    tick(); smp();
    check("t3_end", 32'(gnt_o), 32'd0);

    // Watchdog: master 0 stalls, master 2 queued behind it
    tick();
    drv(0, 1'b1, 1'b1, 1'b0, 32'h300, '0, 4'hF);
    s_dat_i = 32'hCAFE_0000;
    smp();
    check("t4_idle", 32'(gnt_o), 32'd0);
    tick();
    drv(2, 1'b1, 1'b1, 1'b1, 32'h320, 32'h77, 4'h3);
    for (int unsigned s = 1; s <= TO; s++) begin
      if (s > 1) tick();
      if (s == TO) push(4'b0000, 4'b0001, 1'b1, 32'h300, '0, 32'hCAFE_0000, 1'b0, 4'hF);
      smp();
      check($sformatf("t4_scyc%0d", s), 32'(s_cyc_o), 32'd1);
      if (s < TO) begin
        check($sformatf("t4_noerr%0d", s), 32'(m_err_o), 32'd0);
        check($sformatf("t4_noevt%0d", s), 32'(to_evt_o), 32'd0);
      end else begin
        check("t4_err", 32'(m_err_o), 32'h1);
        check("t4_evt", 32'(to_evt_o), 32'd1);
      end
    end
    tick(); smp();
    check("t4_abort_scyc", 32'(s_cyc_o), 32'd0);
    check("t4_abort_stb", 32'(s_stb_o), 32'd0);
    check("t4_abort_gnt", 32'(gnt_o), 32'h1);
    check("t4_abort_err", 32'(m_err_o), 32'd0);
    check("t4_abort_evt", 32'(to_evt_o), 32'd0);
    tick();
    s_ack_i = 1'b1;
    s_err_i = 1'b1;
    smp();
    check("t4_late_ack", 32'(m_ack_o), 32'd0);
    check("t4_late_err", 32'(m_err_o), 32'd0);
    tick();
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    idle_m(0);
    smp();
    check("t4_hold_gnt", 32'(gnt_o), 32'h1);
    check("t4_hold_scyc", 32'(s_cyc_o), 32'd0);
    tick(); smp();
    check("t4_gap", 32'(gnt_o), 32'd0);
    tick();
    s_ack_i = 1'b1;
    push(4'b0100, 4'b0000, 1'b0, 32'h320, 32'h77, '0, 1'b1, 4'h3);
    smp();
    check("t4_next_gnt", 32'(gnt_o), 32'h4);
    tick();
    s_ack_i = 1'b0;
    idle_m(2);
    smp();
    tick(); smp();
    check("t4_end", 32'(gnt_o), 32'd0);

    // Ack lands exactly on the last stall cycle: response wins
    tick();
    drv(3, 1'b1, 1'b1, 1'b1, 32'h400, 32'h4444, 4'hC);
    smp();
    check("t5_idle", 32'(gnt_o), 32'd0);
    tick();
    for (int unsigned s = 1; s <= TO; s++) begin
      if (s > 1) tick();
      if (s == TO) begin
        s_ack_i = 1'b1;
        push(4'b1000, 4'b0000, 1'b0, 32'h400, 32'h4444, '0, 1'b1, 4'hC);
      end
      smp();
      check($sformatf("t5_scyc%0d", s), 32'(s_cyc_o), 32'd1);
    end
    check("t5_ack", 32'(m_ack_o), 32'h8);
    check("t5_noerr", 32'(m_err_o), 32'd0);
    check("t5_noevt", 32'(to_evt_o), 32'd0);
    tick();
    s_ack_i = 1'b0;
    idle_m(3);
    smp();
    check("t5_after_err", 32'(m_err_o), 32'd0);
    tick(); smp();
    check("t5_end", 32'(gnt_o), 32'd0);

    // Asynchronous reset during an active read
    tick();
    drv(1, 1'b1, 1'b1, 1'b0, 32'h500, '0, 4'hF);
    s_dat_i = 32'h0000_6666;
    smp();
    tick(); smp();
    check("t6_gnt", 32'(gnt_o), 32'h2);
    check("t6_scyc", 32'(s_cyc_o), 32'd1);
    #1;
    rstn_i  = 1'b0;
    s_ack_i = 1'b1;
    #1;
    check("t6_rst_scyc", 32'(s_cyc_o), 32'd0);
    check("t6_rst_stb", 32'(s_stb_o), 32'd0);
    check("t6_rst_gnt", 32'(gnt_o), 32'd0);
    check("t6_rst_ack", 32'(m_ack_o), 32'd0);
    tick(); smp();
    check("t6_rst_hold_gnt", 32'(gnt_o), 32'd0);
    tick();
    rstn_i  = 1'b1;
    s_ack_i = 1'b0;
    drv(0, 1'b1, 1'b1, 1'b1, 32'h600, 32'h600D, 4'hF);
    smp();
    check("t6_idle", 32'(gnt_o), 32'd0);
    tick();
    s_ack_i = 1'b1;
    push(4'b0001, 4'b0000, 1'b0, 32'h600, 32'h600D, '0, 1'b1, 4'hF);
    smp();
    check("t6_prio_gnt", 32'(gnt_o), 32'h1);
    tick();
    s_ack_i = 1'b0;
    idle_m(0);
    idle_m(1);
    smp();
    tick(); smp();
    check("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone arbiter that shares one Wishbone slave port among up to NM requesting masters. Typical requesters are the AHB bridge and the USB/ADPCM DMA engines. It sits between the masters and the connection-matrix master port.
- Owns bus grant, per-master ack/err routing, and a stalled-slave watchdog that aborts hung cycles with an error.

## Interface
Parameters:
- NM, 4: number of requesting masters (2..8).
- AW, 32: address width.
- DW, 32: data width; select width is DW/8.
- TO_CYCLES, 255: watchdog limit, in cycles of s_stb_o high without ack/err (1..65535).

Ports:
- clk_i  in  1  Wishbone clock.
- rstn_i  in  1  reset; asynchronous assert, active-low.
- m_cyc_i  in  NM  per-master cycle request.
- m_stb_i  in  NM  per-master strobe.
- m_we_i  in  NM  per-master write enable.
- m_adr_i  in  NM*AW  packed addresses; master k occupies [k*AW +: AW].
- m_dat_i  in  NM*DW  packed write data.
- m_sel_i  in  NM*DW/8  packed byte selects.
- m_dat_o  out  DW  read data, broadcast to all masters (equals s_dat_i).
- m_ack_o  out  NM  ack, routed to owner only.
- m_err_o  out  NM  err, routed to owner only (slave err or watchdog).
- s_cyc_o, s_stb_o, s_we_o  out  1  slave-side controls.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_dat_i  in  DW  slave read data.
- s_ack_i, s_err_i  in  1  slave responses.
- gnt_o  out  NM  one-hot current owner; all zero when no master owns the bus.
- to_evt_o  out  1  one-cycle pulse on watchdog expiry.

## Operation
- Registered state: state (IDLE, OWN, ABORT), owner index, last index, watchdog counter (clog2(TO_CYCLES+1) bits).
- Reset values: state=IDLE, last=NM-1, so master 0 has first priority. Counter=0. All outputs 0.
- IDLE:
  - If any m_cyc_i is set, pick the first set bit searching last+1, last+2, … modulo NM.
  - On the next edge: owner=pick, last=pick, state goes to OWN.
  - No slave outputs are asserted while in IDLE.
- OWN:
  - s_cyc_o = m_cyc_i[owner]; s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o are the owner's fields (combinational mux).
  - m_ack_o[owner] = s_ack_i and m_err_o[owner] = s_err_i, combinational. All other bits are 0.
  - Owner keeps the bus for the whole cycle, including burst/RMW, while m_cyc_i[owner]=1. Other requests wait.
  - If m_cyc_i[owner]=0 at an edge, go to IDLE. At least one IDLE cycle separates owners.
- Watchdog:
  - In OWN, the counter increments each cycle s_stb_o=1 and s_ack_i=0 and s_err_i=0. Otherwise it clears.
  - When counter==TO_CYCLES-1 and the stall persists, that cycle drives m_err_o[owner]=1 and to_evt_o=1, and state goes to ABORT.
- ABORT:
  - s_cyc_o=s_stb_o=0; m_ack_o and m_err_o are 0.
  - Hold until m_cyc_i[owner]=0, then go to IDLE.
  - Late s_ack_i/s_err_i from the slave are ignored.
- Boundary rules:
  - ack (or err) coinciding with watchdog expiry: the slave response wins; no timeout.
  - s_ack_i and s_err_i both high: forward both. Err does not reset ownership.
  - Owner drops cyc in the same cycle as ack: transaction completes and state goes to IDLE.
  - A request whose cyc drops while waiting is simply not picked.
  - rstn_i low mid-cycle: all outputs drop immediately (asynchronous); state returns to reset values.

## Timing
- Grant latency: m_cyc_i rising at edge n (IDLE) gives gnt_o and s_cyc_o at cycle n+1. Worst-case wait equals the sum of other owners' tenures plus one IDLE cycle each.
- Data and response paths are zero-latency combinational in OWN. There are no registers between s_* and m_*.
- Release: owner cyc low is seen at edge k; gnt_o=0 from k+1; next grant at k+2.
- Watchdog error appears TO_CYCLES cycles after s_stb_o first rises without response.

## Structure
- Package wb_arb_pkg holds:
  - the state enum (IDLE/OWN/ABORT);
  - default NM/AW/DW constants;
  - a function for the watchdog counter width.
- Sub-module rr_pick: parameterised NM-bit round-robin priority picker.
  - Inputs: req[NM], last index.
  - Outputs: valid, one-hot grant, index.
  - Purely combinational; reused by other arbiters.

## Test plan
- Single master 0 write, addr 0x0000_0010, data 0xDEAD_BEEF, slave acks after 2 cycles -> s_adr_o/s_dat_o match; m_ack_o=0001 for 1 cycle; gnt_o=0001 from cycle after request.
- Masters 0..3 assert cyc simultaneously after reset, each doing one single access -> grant order 0,1,2,3, each grant separated by one IDLE cycle.
- Master 2 holds cyc for a 4-beat burst while master 1 requests -> gnt_o stays 0100 for all 4 acks; master 1 granted 2 cycles after master 2 drops cyc.
- TO_CYCLES=8, slave never acks -> m_err_o[owner] and to_evt_o pulse on the 8th stall cycle; s_cyc_o=0 until owner drops cyc; next requester then granted.
- Slave ack arrives exactly on the 8th stall cycle (TO_CYCLES=8) -> ack forwarded, no err, no to_evt_o.
- rstn_i pulsed low during an active read -> s_cyc_o, gnt_o and m_ack_o are 0 immediately; after release, master 0 has first priority.
